// File: rtl/gate_response_checker.sv
// gate_response_checker
// Self-checking harness for a 2-input combinational gate. It sweeps {a,b}
// through 00,01,10,11 (PASSES times), holds each vector for SETTLE+2 cycles,
// compares the gate's response against the EXPECT truth table and reports
// a saturating mismatch count plus the first failing vector.

module gate_response_checker #(
    parameter logic [3:0] EXPECT = 4'b1110,
    parameter int         SETTLE = 1,
    parameter int         PASSES = 1,
    parameter int         CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             s,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [1:0]       first_fail_vec,
    output logic             first_fail_valid
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0]       SETTLE_CNT = 4'(SETTLE);
    localparam logic [7:0]       LAST_PASS  = 8'(PASSES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           r_state;
    state_t           w_nextState;
    logic [1:0]       r_vec;
    logic [7:0]       r_passIdx;
    logic [3:0]       r_waitCnt;
    logic [1:0]       r_ab;
    logic [CNT_W-1:0] r_errCount;
    logic [1:0]       r_firstFailVec;
    logic             r_firstFailValid;
    logic             r_pass;
    logic             w_mismatch;
    logic             w_lastVec;
    logic             w_lastPass;
    logic             w_busy;
    logic             w_done;

    assign w_mismatch = (s != EXPECT[r_vec]);
    assign w_lastVec  = (r_vec == 2'b11);
    assign w_lastPass = (r_passIdx == LAST_PASS);

    // State register; reset aborts any run in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode plus the busy/done status derived from the state
    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                w_busy = 1'b1;
                if (r_waitCnt == 4'd0) begin
                    w_nextState = SAMPLE;
                end
            end
            SAMPLE: begin
                w_busy = 1'b1;
                if (w_lastVec && w_lastPass) begin
                    w_nextState = DONE;
                end else begin
                    w_nextState = HOLD;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Sweep datapath: vector/pass counters, settle timer, result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec            <= 2'b00;
            r_passIdx        <= 8'd0;
            r_waitCnt        <= 4'd0;
            r_ab             <= 2'b00;
            r_errCount       <= '0;
            r_firstFailVec   <= 2'b00;
            r_firstFailValid <= 1'b0;
            r_pass           <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_vec            <= 2'b00;
                        r_passIdx        <= 8'd0;
                        r_waitCnt        <= SETTLE_CNT;
                        r_ab             <= 2'b00;
                        r_errCount       <= '0;
                        r_firstFailVec   <= 2'b00;
                        r_firstFailValid <= 1'b0;
                        r_pass           <= 1'b0;
                    end
                end
                HOLD: begin
                    if (r_waitCnt != 4'd0) begin
                        r_waitCnt <= r_waitCnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    if (w_mismatch) begin
                        if (r_errCount != CNT_MAX) begin
                            r_errCount <= r_errCount + CNT_ONE;
                        end
                        if (!r_firstFailValid) begin
                            r_firstFailVec   <= r_vec;
                            r_firstFailValid <= 1'b1;
                        end
                    end
                    if (!w_lastVec) begin
                        r_vec     <= r_vec + 2'd1;
                        r_ab      <= r_vec + 2'd1;
                        r_waitCnt <= SETTLE_CNT;
                    end else if (!w_lastPass) begin
                        r_vec     <= 2'b00;
                        r_ab      <= 2'b00;
                        r_passIdx <= r_passIdx + 8'd1;
                        r_waitCnt <= SETTLE_CNT;
                    end else begin
                        r_ab <= 2'b00;
                    end
                end
                DONE: begin
                    r_pass <= (r_errCount == '0);
                end
                default: begin
                    r_ab <= 2'b00;
                end
            endcase
        end
    end

    assign a                = r_ab[1];
    assign b                = r_ab[0];
    assign busy             = w_busy;
    assign done             = w_done;
    assign pass             = r_pass;
    assign err_count        = r_errCount;
    assign first_fail_vec   = r_firstFailVec;
    assign first_fail_valid = r_firstFailValid;

endmodule

// File: tb/tb_gate_response_checker.sv
// tb_gate_response_checker
// Four checker instances with different parameter sets, each watching a
// gate whose truth table is chosen by the bench. Expected results come from
// a truth-table model: per-pass mismatches = differing table bits.

module tb_gate_response_checker;

    localparam int CFG_SETTLE[4] = '{1, 1, 0, 1};
    localparam int CFG_PASSES[4] = '{1, 1, 3, 4};
    localparam int CFG_W[4]      = '{8, 8, 8, 2};
    localparam int CFG_EXP[4]    = '{14, 8, 14, 14};

    logic            clk;
    logic            rst_n;
    logic [3:0]      start;
    logic [3:0]      s;
    logic [3:0]      a;
    logic [3:0]      b;
    logic [3:0]      busy;
    logic [3:0]      done;
    logic [3:0]      pass;
    logic [3:0]      ffValid;
    logic [3:0][1:0] ffVec;
    logic [3:0][7:0] errCnt;
    logic [3:0][3:0] tbl;
    logic [1:0]      errNarrow;

    int checks = 0;
    int errors = 0;

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural gates under test: s looks up the chosen truth table
    assign s[0] = tbl[0][{a[0], b[0]}];
    assign s[1] = tbl[1][{a[1], b[1]}];
    assign s[2] = tbl[2][{a[2], b[2]}];
    assign s[3] = tbl[3][{a[3], b[3]}];
    assign errCnt[3] = {6'b0, errNarrow};

    gate_response_checker #(.EXPECT(4'(CFG_EXP[0])), .SETTLE(CFG_SETTLE[0]), .PASSES(CFG_PASSES[0]), .CNT_W(CFG_W[0])) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .s(s[0]), .a(a[0]), .b(b[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(errCnt[0]),
        .first_fail_vec(ffVec[0]), .first_fail_valid(ffValid[0]));

    gate_response_checker #(.EXPECT(4'(CFG_EXP[1])), .SETTLE(CFG_SETTLE[1]), .PASSES(CFG_PASSES[1]), .CNT_W(CFG_W[1])) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .s(s[1]), .a(a[1]), .b(b[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(errCnt[1]),
        .first_fail_vec(ffVec[1]), .first_fail_valid(ffValid[1]));

    gate_response_checker #(.EXPECT(4'(CFG_EXP[2])), .SETTLE(CFG_SETTLE[2]), .PASSES(CFG_PASSES[2]), .CNT_W(CFG_W[2])) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .s(s[2]), .a(a[2]), .b(b[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(errCnt[2]),
        .first_fail_vec(ffVec[2]), .first_fail_valid(ffValid[2]));

    gate_response_checker #(.EXPECT(4'(CFG_EXP[3])), .SETTLE(CFG_SETTLE[3]), .PASSES(CFG_PASSES[3]), .CNT_W(CFG_W[3])) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start[3]), .s(s[3]), .a(a[3]), .b(b[3]),
        .busy(busy[3]), .done(done[3]), .pass(pass[3]), .err_count(errNarrow),
        .first_fail_vec(ffVec[3]), .first_fail_valid(ffValid[3]));

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int allOutputs(input int k);
        return int'({a[k], b[k], busy[k], done[k], pass[k], ffValid[k], ffVec[k], errCnt[k]});
    endfunction

    // One complete run on instance k with gate truth table t
    task automatic applyStimulus(input int k, input logic [3:0] t, input bit midStart, input bit doneStart);
        int         win;
        int         expLen;
        int         nDiff;
        int         firstIdx;
        int         expErr;
        int         maxCnt;
        int         busyCyc;
        int         seqBad;
        int         cyc;
        int         extra;
        bit         seenDone;
        logic [3:0] e;
        e        = 4'(CFG_EXP[k]);
        win      = CFG_SETTLE[k] + 2;
        expLen   = 4 * CFG_PASSES[k] * win;
        nDiff    = 0;
        firstIdx = 0;
        for (int v = 0; v < 4; v++) begin
            if (t[v] != e[v]) begin
                if (nDiff == 0) firstIdx = v;
                nDiff++;
            end
        end
        maxCnt = (1 << CFG_W[k]) - 1;
        expErr = nDiff * CFG_PASSES[k];
        if (expErr > maxCnt) expErr = maxCnt;

        tbl[k] = t;
        @(negedge clk);
        start[k] = 1'b1;
        busyCyc  = 0;
        seqBad   = 0;
        cyc      = 0;
        seenDone = 1'b0;
        while (!seenDone && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start[k] = 1'b0;
                checkOutput($sformatf("clrErr%0d", k), int'(errCnt[k]), 0);
                checkOutput($sformatf("clrValid%0d", k), int'(ffValid[k]), 0);
                checkOutput($sformatf("clrPass%0d", k), int'(pass[k]), 0);
            end
            if (midStart) start[k] = (cyc == 3);
            if (busy[k]) begin
                if (int'({a[k], b[k]}) != (busyCyc / win) % 4) seqBad++;
                busyCyc++;
            end else if (done[k]) begin
                seenDone = 1'b1;
                if ({a[k], b[k]} != 2'b00) seqBad++;
            end else begin
                seqBad++;
            end
        end
        if (doneStart) start[k] = 1'b1;
        checkOutput($sformatf("doneSeen%0d", k), int'(seenDone), 1);
        checkOutput($sformatf("busyLen%0d", k), busyCyc, expLen);
        checkOutput($sformatf("abSeq%0d", k), seqBad, 0);

        extra = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (j == 0) start[k] = 1'b0;
            if (busy[k] || done[k] || a[k] || b[k]) extra++;
        end
        checkOutput($sformatf("noRestart%0d", k), extra, 0);
        checkOutput($sformatf("errCount%0d", k), int'(errCnt[k]), expErr);
        checkOutput($sformatf("pass%0d", k), int'(pass[k]), (nDiff == 0) ? 1 : 0);
        checkOutput($sformatf("ffValid%0d", k), int'(ffValid[k]), (nDiff > 0) ? 1 : 0);
        checkOutput($sformatf("ffVec%0d", k), int'(ffVec[k]), firstIdx);
    endtask

    // Main sequence: reset, directed runs, reset abort, randomized runs
    initial begin
        int watch;
        rst_n = 1'b0;
        start = 4'b0;
        tbl   = {4'b1110, 4'b1110, 4'b1110, 4'b1110};
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) checkOutput($sformatf("rst%0d", k), allOutputs(k), 0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(0, 4'b1110, 1'b0, 1'b0);
        applyStimulus(0, 4'b0000, 1'b0, 1'b0);
        applyStimulus(0, 4'b1000, 1'b0, 1'b0);
        applyStimulus(1, 4'b0000, 1'b0, 1'b0);
        applyStimulus(1, 4'b1000, 1'b0, 1'b0);
        applyStimulus(2, 4'b1111, 1'b0, 1'b0);
        applyStimulus(3, 4'b0001, 1'b0, 1'b0);
        applyStimulus(0, 4'b0000, 1'b1, 1'b1);
        applyStimulus(0, 4'b1110, 1'b1, 1'b1);

        tbl[0] = 4'b0110;
        @(negedge clk);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("preRstB", int'({busy[0], b[0]}), 3);
        #1 rst_n = 1'b0;
        #1 checkOutput("rstAbort", allOutputs(0), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        watch = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (busy[0] || done[0]) watch++;
        end
        checkOutput("noDoneAfterRst", watch, 0);
        applyStimulus(0, 4'b1110, 1'b0, 1'b0);

        for (int n = 0; n < 24; n++) begin
            int gap;
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            applyStimulus(int'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
